// File: rtl/paddle_button_conditioner.sv
// Paddle push-button conditioner: per-channel 2-flop synchroniser, counter debounce,
// press/release edge pulses and auto-repeat pulses while a button is held.
module paddle_button_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               ACTIVE_LOW      = 1,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = {N_BTN{1'b1}}
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE   = DW'(1);
    localparam logic [RW-1:0] DLY_LAST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : RW'(0);
    localparam logic [RW-1:0] PER_LAST = (REPEAT_PERIOD > 0) ? RW'(REPEAT_PERIOD - 1) : RW'(0);
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_BTN-1:0] raw_pressed_s;
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Polarity is corrected before synchronising so "not pressed" is always 0 inside.
    assign raw_pressed_s = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q <= {N_BTN{1'b0}};
            sync2_q <= {N_BTN{1'b0}};
        end else begin
            sync1_q <= raw_pressed_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        localparam logic RPT_EN = REPEAT_MASK[i] && (REPEAT_DELAY > 0);

        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        logic [DW-1:0] db_cnt_q;
        logic [DW-1:0] db_cnt_d;
        logic          toggle_s;
        logic          rise_s;
        logic          fall_s;
        rpt_state_e    state_q;
        rpt_state_e    state_d;
        logic [RW-1:0] rpt_cnt_q;
        logic [RW-1:0] rpt_cnt_d;
        logic          repeat_d;

        // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
        always_comb begin
            toggle_s = 1'b0;
            db_cnt_d = {DW{1'b0}};
            if (sync2_q[i] != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    toggle_s = 1'b1;
                    db_cnt_d = {DW{1'b0}};
                end else begin
                    toggle_s = 1'b0;
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end else begin
                toggle_s = 1'b0;
                db_cnt_d = {DW{1'b0}};
            end
        end

        assign rise_s = toggle_s & ~level_q;
        assign fall_s = toggle_s & level_q;

        // Auto-repeat next-state logic; a falling level always wins and suppresses the pulse.
        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            repeat_d  = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    rpt_cnt_d = {RW{1'b0}};
                    if (rise_s && RPT_EN) begin
                        state_d = RPT_DELAY;
                    end else begin
                        state_d = RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (fall_s) begin
                        state_d   = RPT_IDLE;
                        rpt_cnt_d = {RW{1'b0}};
                    end else if (rpt_cnt_q == DLY_LAST) begin
                        state_d   = RPT_REPEAT;
                        rpt_cnt_d = {RW{1'b0}};
                        repeat_d  = 1'b1;
                    end else begin
                        state_d   = RPT_DELAY;
                    end
                end
                RPT_REPEAT: begin
                    if (fall_s) begin
                        state_d   = RPT_IDLE;
                        rpt_cnt_d = {RW{1'b0}};
                    end else if (rpt_cnt_q == PER_LAST) begin
                        rpt_cnt_d = {RW{1'b0}};
                        repeat_d  = 1'b1;
                    end else begin
                        state_d   = RPT_REPEAT;
                    end
                end
                default: begin
                    state_d   = RPT_IDLE;
                    rpt_cnt_d = {RW{1'b0}};
                end
            endcase
        end

        // Per-channel state and registered outputs.
        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                db_cnt_q  <= {DW{1'b0}};
                state_q   <= RPT_IDLE;
                rpt_cnt_q <= {RW{1'b0}};
            end else begin
                level_q   <= level_q ^ toggle_s;
                press_q   <= rise_s;
                release_q <= fall_s;
                repeat_q  <= repeat_d;
                db_cnt_q  <= db_cnt_d;
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_paddle_button_conditioner.sv
// Bench for paddle_button_conditioner: a vector table, directed multi-cycle sequences
// and random stimulus, all checked every cycle against a behavioural model.
module tb_paddle_button_conditioner;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;
    localparam logic [3:0] MASK = 4'b0111;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    paddle_button_conditioner #(
        .N_BTN(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .REPEAT_MASK(MASK)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Behavioural model state: synchroniser modelled as a two-sample delay line,
    // debounce as a run length of disagreeing samples, repeat from the age of the hold.
    logic [3:0] m_dly[$];
    logic [3:0] m_lvl, m_press, m_rel, m_rpt;
    int         m_run[4];
    int         m_age[4];

    int n_press[4], n_rel[4], n_rpt[4];
    int last_press[4], last_rel[4], first_rpt[4];
    int rpt0_q[$];

    typedef struct {
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got 'h%0h expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dly = {4'b0000, 4'b0000};
        m_lvl = 4'b0000; m_press = 4'b0000; m_rel = 4'b0000; m_rpt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic rn);
        logic [3:0] synced;
        if (!rn) begin
            model_reset();
        end else begin
            synced = m_dly.pop_front();
            m_dly.push_back(~raw);
            m_press = 4'b0000; m_rel = 4'b0000; m_rpt = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (synced[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_run[i] = 0;
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) m_press[i] = 1'b1;
                        else          m_rel[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_press[i]) m_age[i] = 0;
                else if (m_lvl[i]) m_age[i]++;
                if (m_lvl[i] && !m_press[i] && MASK[i] && DELAY > 0 && m_age[i] >= DELAY
                    && ((m_age[i] - DELAY) % PERIOD) == 0)
                    m_rpt[i] = 1'b1;
            end
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_rpt[i] = 0;
            last_press[i] = -1; last_rel[i] = -1; first_rpt[i] = -1;
        end
        rpt0_q.delete();
    endtask

    // One clock: drive, advance model, clock the DUT, sample on the falling edge.
    task automatic tick(input logic [3:0] raw, input logic rn);
        btn_raw = raw;
        rst_n   = rn;
        cyc++;
        model_edge(raw, rn);
        @(posedge clk);
        @(negedge clk);
        chk("model", {16'h0, btn_level, btn_press, btn_release, btn_repeat},
            {16'h0, m_lvl, m_press, m_rel, m_rpt});
        for (int i = 0; i < 4; i++) begin
            if (btn_press[i])   begin n_press[i]++; last_press[i] = cyc; end
            if (btn_release[i]) begin n_rel[i]++;   last_rel[i]   = cyc; end
            if (btn_repeat[i]) begin
                if (n_rpt[i] == 0) first_rpt[i] = cyc;
                n_rpt[i]++;
                if (i == 0) rpt0_q.push_back(cyc);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(4'b1111, 1'b1);
    endtask

    initial begin
        int e;
        int f;
        logic [3:0] r;

        btn_raw = 4'b1111;
        rst_n   = 1'b0;
        model_reset();
        clr_counts();
        @(negedge clk);

        // Reset with buttons released, then 20 quiet cycles.
        for (int k = 0; k < 5; k++) tick(4'b1111, 1'b0);
        chk("reset_outputs", {16'h0, btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        idle(20);
        chk("post_reset_quiet", n_press[0] + n_rel[0] + n_rpt[0], 32'd0);

        // Table: all four pressed on one edge, then released on one edge.
        for (int k = 0; k < 15; k++) begin
            tbl[k].raw   = (k < 8) ? 4'b0000 : 4'b1111;
            tbl[k].lvl   = (k >= 5 && k < 13) ? 4'b1111 : 4'b0000;
            tbl[k].press = (k == 5)  ? 4'b1111 : 4'b0000;
            tbl[k].rel   = (k == 13) ? 4'b1111 : 4'b0000;
            tbl[k].rpt   = 4'b0000;
        end
        for (int k = 0; k < 15; k++) begin
            tick(tbl[k].raw, 1'b1);
            chk($sformatf("tbl_row%0d", k), {16'h0, btn_level, btn_press, btn_release, btn_repeat},
                {16'h0, tbl[k].lvl, tbl[k].press, tbl[k].rel, tbl[k].rpt});
        end
        idle(5);

        // Clean press on channel 0 held 30 cycles.
        clr_counts();
        e = cyc + 1;
        for (int k = 0; k < 30; k++) tick(4'b1110, 1'b1);
        idle(10);
        chk("clean_press_time", last_press[0], e + 5);
        chk("clean_press_count", n_press[0], 32'd1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("clean_rpt%0d", k), (rpt0_q.size() > k) ? rpt0_q[k] : -1,
                e + 5 + DELAY + k * PERIOD);
        chk("clean_rpt_count", n_rpt[0], 32'd7);
        chk("clean_others_quiet", n_press[1] + n_press[2] + n_press[3], 32'd0);

        // Bounce on channel 1, then a steady low.
        clr_counts();
        for (int k = 0; k < 20; k++) tick(((k / 2) % 2 == 0) ? 4'b1101 : 4'b1111, 1'b1);
        e = cyc + 1;
        for (int k = 0; k < 15; k++) tick(4'b1101, 1'b1);
        chk("bounce_no_release", n_rel[1], 32'd0);
        chk("bounce_press_count", n_press[1], 32'd1);
        chk("bounce_press_time", last_press[1], e + 5);
        idle(10);

        // Release of channel 2 inside the repeat delay, then a fresh press.
        clr_counts();
        e = cyc + 1;
        for (int k = 0; k < 6; k++) tick(4'b1011, 1'b1);
        idle(15);
        chk("middelay_release_count", n_rel[2], 32'd1);
        chk("middelay_release_time", last_rel[2], e + 11);
        chk("middelay_no_repeat", n_rpt[2], 32'd0);
        f = cyc + 1;
        for (int k = 0; k < 14; k++) tick(4'b1011, 1'b1);
        idle(10);
        chk("repress_first_repeat", first_rpt[2], f + 5 + DELAY);

        // Masked channel 3 held alongside channel 0.
        clr_counts();
        for (int k = 0; k < 40; k++) tick(4'b0110, 1'b1);
        idle(10);
        chk("masked_press_count", n_press[3], 32'd1);
        chk("masked_no_repeat", n_rpt[3], 32'd0);
        chk("unmasked_repeat_count", n_rpt[0], 32'd10);
        chk("masked_same_press_cycle", last_press[3], last_press[0]);

        // Reset in the middle of a debounce.
        clr_counts();
        for (int k = 0; k < 3; k++) tick(4'b1110, 1'b1);
        for (int k = 0; k < 3; k++) tick(4'b1110, 1'b0);
        idle(10);
        chk("mid_debounce_reset_no_pulse", n_press[0] + n_rel[0], 32'd0);

        // Button held through reset is detected afresh.
        clr_counts();
        for (int k = 0; k < 3; k++) tick(4'b1101, 1'b0);
        e = cyc + 1;
        for (int k = 0; k < 8; k++) tick(4'b1101, 1'b1);
        idle(10);
        chk("held_through_reset_press", last_press[1], e + 5);

        // Random activity with occasional resets.
        r = 4'b1111;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(9) == 0) r[i] = ~r[i];
            tick(r, ($urandom_range(299) == 0) ? 1'b0 : 1'b1);
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
